// File: rtl/pudding_chain_sequencer.sv
// Byte-stream to pin-level sequencer for the PUDDING configuration chain.
// Optional write-verify readback with CRC-8 when PUDDING_SEQ_VERIFY_EN is defined.
`timescale 1ns/1ps
module pudding_chain_sequencer #(
  parameter int CHAIN_LEN = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  input  logic       chain_msb,
  output logic       datum,
  output logic       shift,
  output logic       transfer,
  output logic       dir,
  output logic       stateen,
  output logic       busy,
  output logic       done,
  output logic       verify_err
);

  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int CW     = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES * 8);

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_COMMIT  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_WR_B, S_COMMIT, S_RESTORE, S_RD_A, S_RD_B, S_RD_OUT, S_DONE
`ifdef PUDDING_SEQ_VERIFY_EN
    , S_VR_RESTORE, S_VR_A, S_VR_B
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    sh, sh_nxt;
  logic [1:0]    op, op_nxt;
  logic          datum_nxt, dir_nxt, shift_nxt, transfer_nxt;
  logic          wr_ready_nxt, rd_valid_nxt;
  logic [7:0]    rd_data_nxt;
  logic          nx_phase_a, nx_phase_b;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    op_nxt    = op;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (cmd_valid && cmd_ready) begin
          op_nxt = cmd_op;
          case (cmd_op)
            OP_WRITE:  state_nxt = S_WR_A;
            OP_COMMIT: state_nxt = S_COMMIT;
            default:   state_nxt = S_RESTORE;
          endcase
        end
      end
      S_WR_A: begin
        // wr_ready is high only at a byte boundary; elsewhere the byte is already loaded
        if (!wr_ready) begin
          state_nxt = S_WR_B;
        end else if (wr_valid) begin
          sh_nxt    = wr_data;
          state_nxt = S_WR_B;
        end
      end
      S_WR_B: begin
        sh_nxt    = {sh[6:0], 1'b0};
        cnt_nxt   = cnt + CW'(1);
        state_nxt = (cnt_nxt == LAST) ? S_COMMIT : S_WR_A;
      end
      S_COMMIT: begin
`ifdef PUDDING_SEQ_VERIFY_EN
        state_nxt = (op == OP_WRITE) ? S_VR_RESTORE : S_DONE;
`else
        state_nxt = S_DONE;
`endif
      end
      S_RESTORE: state_nxt = (op == OP_READ) ? S_RD_A : S_DONE;
      S_RD_A: begin
        sh_nxt    = {sh[6:0], chain_msb};
        state_nxt = S_RD_B;
      end
      S_RD_B: begin
        cnt_nxt   = cnt + CW'(1);
        state_nxt = (cnt_nxt[2:0] == 3'd0) ? S_RD_OUT : S_RD_A;
      end
      S_RD_OUT: begin
        if (rd_ready) state_nxt = (cnt == LAST) ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
`ifdef PUDDING_SEQ_VERIFY_EN
      S_VR_RESTORE: state_nxt = S_VR_A;
      S_VR_A:       state_nxt = S_VR_B;
      // readback counts back down so the counter only clears on return to IDLE
      S_VR_B: begin
        cnt_nxt   = cnt - CW'(1);
        state_nxt = (cnt_nxt == '0) ? S_DONE : S_VR_A;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase

`ifdef PUDDING_SEQ_VERIFY_EN
    nx_phase_a = (state_nxt == S_RD_A) || (state_nxt == S_VR_A);
    nx_phase_b = (state_nxt == S_RD_B) || (state_nxt == S_VR_B);
    transfer_nxt = (state_nxt == S_COMMIT) || (state_nxt == S_RESTORE) ||
                   (state_nxt == S_VR_RESTORE);
`else
    nx_phase_a = (state_nxt == S_RD_A);
    nx_phase_b = (state_nxt == S_RD_B);
    transfer_nxt = (state_nxt == S_COMMIT) || (state_nxt == S_RESTORE);
`endif
    shift_nxt = (state_nxt == S_WR_B) || nx_phase_b;

    dir_nxt = dir;
    if (state_nxt == S_COMMIT) dir_nxt = 1'b1;
    else if (transfer_nxt)     dir_nxt = 1'b0;

    if ((state_nxt == S_WR_A) || (state_nxt == S_WR_B)) datum_nxt = sh_nxt[7];
    else if (nx_phase_b)                                  datum_nxt = chain_msb;
    else if (nx_phase_a)                                  datum_nxt = datum;
    else                                                  datum_nxt = 1'b0;

    wr_ready_nxt = (state_nxt == S_WR_A) && (cnt_nxt[2:0] == 3'd0);
    rd_valid_nxt = (state_nxt == S_RD_OUT);
    rd_data_nxt  = rd_valid_nxt ? sh_nxt : rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sh        <= '0;
      op        <= '0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      datum     <= 1'b0;
      shift     <= 1'b0;
      transfer  <= 1'b0;
      dir       <= 1'b0;
      stateen   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sh        <= sh_nxt;
      op        <= op_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      wr_ready  <= wr_ready_nxt;
      rd_data   <= rd_data_nxt;
      rd_valid  <= rd_valid_nxt;
      datum     <= datum_nxt;
      shift     <= shift_nxt;
      transfer  <= transfer_nxt;
      dir       <= dir_nxt;
      stateen   <= 1'b1;
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
    end
  end

`ifdef PUDDING_SEQ_VERIFY_EN
  logic [7:0] crc_wr, crc_rd;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    crc8_step = {c[6:0], 1'b0} ^ (((c[7] ^ b) == 1'b1) ? 8'h07 : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_wr     <= '0;
      crc_rd     <= '0;
      verify_err <= 1'b0;
    end else begin
      if ((state == S_IDLE) && (state_nxt != S_IDLE)) begin
        crc_wr <= '0;
        crc_rd <= '0;
      end
      if (state == S_WR_B) crc_wr <= crc8_step(crc_wr, sh[7]);
      if (state == S_VR_A) crc_rd <= crc8_step(crc_rd, chain_msb);
      if ((state == S_VR_B) && (state_nxt == S_DONE) && (crc_rd != crc_wr))
        verify_err <= 1'b1;
    end
  end
`else
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_pudding_chain_sequencer.sv
// Scoreboard bench for pudding_chain_sequencer with a pin-level chain model and byte-level reference.
`timescale 1ns/1ps
module tb_pudding_chain_sequencer;
  localparam int CL = 128;
  localparam int NB = CL / 8;
`ifdef PUDDING_SEQ_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] wr_data = 8'h00;
  logic chain_msb;
  logic cmd_ready, wr_ready, rd_valid, datum, shift, transfer, dir, stateen, busy, done, verify_err;
  logic [7:0] rd_data;

  pudding_chain_sequencer #(.CHAIN_LEN(CL)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .chain_msb(chain_msb), .datum(datum),
    .shift(shift), .transfer(transfer), .dir(dir), .stateen(stateen), .busy(busy),
    .done(done), .verify_err(verify_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int nshift = 0, ntrans = 0, ndir1 = 0;
  logic [CL-1:0] chain, sreg;
  logic corrupt_arm = 1'b0;
  logic [7:0] ref_bytes [NB];
  logic [7:0] wbytes [NB];
  logic [7:0] sb_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Environment: the chain itself (transfer outranks shift)
  assign chain_msb = chain[CL-1];
  always @(posedge clk) begin
    if (transfer) begin
      if (dir) sreg <= chain;
      else     chain <= sreg ^ {{(CL-1){1'b0}}, corrupt_arm};
    end else if (shift) begin
      chain <= {chain[CL-2:0], datum};
    end
    if (rst_n) begin
      if (shift) nshift++;
      if (transfer) begin
        ntrans++;
        if (dir) ndir1++;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid && rd_ready) begin
        if (sb_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", rd_data, sb_q.pop_front());
      end
      if (shift || transfer) chk("strobe_excl", shift & transfer, 0);
    end
  end

  function automatic logic [CL-1:0] exp_state();
    logic [CL-1:0] v = '0;
    for (int i = 0; i < NB; i++) v = {v[CL-9:0], ref_bytes[i]};
    return v;
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(posedge clk); #1;
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_write(input int gap_byte, input int gap_len, input int abort_at,
                          input bit spam, input bit exp_verr);
    int idx = 0, gcnt = 0, cyc = 1;
    bit ok, got_done = 1'b0;
    wait_idle(ok);
    if (!ok) return;
    nshift = 0; ntrans = 0; ndir1 = 0;
    cmd_op = 2'b00; cmd_valid = 1'b1; wr_valid = 1'b0;
    for (int t = 0; t < 4 * CL + 100 + gap_len; t++) begin
      @(posedge clk); #1;
      cyc++;
      cmd_valid = spam && !cmd_ready;
      cmd_op = spam ? 2'b01 : 2'b00;
      if (abort_at > 0 && nshift == abort_at) begin
        rst_n = 1'b0; wr_valid = 1'b0; cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_outputs", {cmd_ready, shift, transfer, datum, wr_ready, busy, done, stateen}, 8'h80);
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (done) begin got_done = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0; break; end
      if (wr_ready && idx == gap_byte && gcnt < gap_len) begin
        wr_valid = 1'b0; gcnt++;
        chk("wr_gap_shift", shift, 0);
      end else begin
        wr_valid = 1'b1;
        wr_data = (idx < NB) ? wbytes[idx] : 8'h00;
        if (wr_ready) idx++;
      end
    end
    chk("wr_done_seen", got_done, 1);
    if (!got_done) return;
    chk("wr_latency", cyc, 2 * CL + 3 + VER * (2 * CL + 1) + gap_len);
    chk("wr_bytes_used", idx, NB);
    chk("wr_shifts", nshift, CL * (1 + VER));
    chk("wr_transfers", {ntrans, ndir1}, {1 + VER, 1});
    for (int i = 0; i < NB; i++) ref_bytes[i] = wbytes[i];
    chk("state_reg", sreg, exp_state());
    chk("verify_err", verify_err, exp_verr);
  endtask

  task automatic do_read(input int stall_byte, input int stall_len, input bit rand_ready);
    int bidx = 0, scnt = 0, nwr_bad = 0;
    bit ok, got_done = 1'b0;
    wait_idle(ok);
    if (!ok) return;
    nshift = 0; ntrans = 0; ndir1 = 0;
    for (int i = 0; i < NB; i++) sb_q.push_back(ref_bytes[i]);
    cmd_op = 2'b01; cmd_valid = 1'b1;
    for (int t = 0; t < 6 * CL + 200 + stall_len; t++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wr_valid = 1'($urandom % 2);
      if (wr_ready) nwr_bad++;
      if (done) begin got_done = 1'b1; rd_ready = 1'b0; break; end
      if (rd_valid && bidx == stall_byte && scnt < stall_len) begin
        rd_ready = 1'b0; scnt++;
        chk("rd_stall", {rd_valid, shift, rd_data}, {1'b1, 1'b0, ref_bytes[stall_byte]});
      end else begin
        rd_ready = rand_ready ? ($urandom % 3 != 0) : 1'b1;
        if (rd_valid && rd_ready) bidx++;
      end
    end
    wr_valid = 1'b0;
    chk("rd_done_seen", got_done, 1);
    chk("rd_bytes", bidx, NB);
    chk("rd_sb_empty", sb_q.size(), 0);
    sb_q.delete();
    chk("rd_nondestructive", chain, sreg);
    chk("rd_chain_top", chain[CL-1 -: 8], ref_bytes[0]);
    chk("rd_strobes", {nshift, ntrans, ndir1}, {CL, 1, 0});
    chk("rd_wr_ready_idle", nwr_bad, 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < CL; i++) begin
      chain[i] = 1'($urandom % 2);
      sreg[i]  = 1'($urandom % 2);
    end
    for (int i = 0; i < NB; i++) ref_bytes[i] = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {cmd_ready, wr_ready, rd_valid, rd_data, datum, shift, transfer, dir,
                          stateen, busy, done, verify_err}, 19'h40000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset", {stateen, cmd_ready, busy}, 3'b110);

    for (int i = 0; i < NB; i++) wbytes[i] = 8'(i + 1);
    do_write(-1, 0, 0, 1'b0, 1'b0);
    chk("state_top_byte", sreg[CL-1 -: 8], 8'h01);
    chk("state_low_byte", sreg[7:0], 8'h10);
    do_read(-1, 0, 1'b0);
    do_write(3, 5, 0, 1'b0, 1'b0);
    do_read(5, 10, 1'b0);

    for (int i = 0; i < NB; i++) wbytes[i] = 8'($urandom);
    do_write(-1, 0, 60, 1'b1, 1'b0);
    do_write(-1, 0, 0, 1'b1, 1'b0);
    do_read(-1, 0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NB; i++) wbytes[i] = 8'($urandom);
      do_write($urandom_range(0, NB - 1), $urandom_range(0, 6), 0, 1'b0, 1'b0);
      do_read($urandom_range(0, NB - 1), $urandom_range(0, 12), 1'b1);
    end

`ifdef PUDDING_SEQ_VERIFY_EN
    for (int i = 0; i < NB; i++) wbytes[i] = 8'($urandom);
    corrupt_arm = 1'b1;
    do_write(-1, 0, 0, 1'b0, 1'b1);
    corrupt_arm = 1'b0;
    do_write(-1, 0, 0, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("verify_err_reset", verify_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
